// File: rtl/enc_pack_scheduler_pkg.sv
// Shared HDC encoder definitions: pack geometry, scheduler FSM state type and
// the per-binder shift table used inside each binder pack.
package enc_pack_scheduler_pkg;

  function automatic int unsigned ceil_div(input int unsigned a, input int unsigned b);
    return (a + b - 1) / b;
  endfunction

  localparam int unsigned PACK_W        = 10;
  localparam int unsigned NUM_FEATURES  = 620;
  localparam int unsigned ENC_NUM_PACKS = ceil_div(NUM_FEATURES, PACK_W);
  localparam int unsigned HV_W          = 8;

  // Rotation applied by binder b of every pack.
  localparam int unsigned SHIFTS [PACK_W] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9};

  // Encodings kept identical to the legacy localparam values.
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ISSUE   = 3'd1;
  localparam logic [2:0] S_WAIT    = 3'd2;
  localparam logic [2:0] S_PRESENT = 3'd3;
  localparam logic [2:0] S_FINISH  = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE    = S_IDLE,
    ST_ISSUE   = S_ISSUE,
    ST_WAIT    = S_WAIT,
    ST_PRESENT = S_PRESENT,
    ST_FINISH  = S_FINISH
  } enc_sched_state_t;

endpackage

// File: rtl/enc_pack_scheduler_if.sv
// Scheduler bus: sample-load request, per-pack start strobes, pack index,
// bundler valid/ready/last handshake, status, and the pack result datapath.
//   master : scheduler side (drives strobes, index, handshake, status, acc_hv)
//   slave  : environment side (drives start, acc_ready, shifted_hv)
interface enc_pack_scheduler_if
  import enc_pack_scheduler_pkg::*;
#(
  parameter int unsigned NUM_PACKS = ENC_NUM_PACKS,
  parameter int unsigned IDX_W     = (NUM_PACKS > 1) ? $clog2(NUM_PACKS) : 1,
  parameter int unsigned HV_BITS   = HV_W
);
  logic                                       start;
  logic [NUM_PACKS-1:0]                       pack_start;
  logic [IDX_W-1:0]                           pack_idx;
  logic                                       acc_valid;
  logic                                       acc_ready;
  logic                                       acc_last;
  logic                                       busy;
  logic                                       done;
  logic [NUM_PACKS-1:0][PACK_W*HV_BITS-1:0]   shifted_hv;
  logic [PACK_W*HV_BITS-1:0]                  acc_hv;

  modport master (
    input  start, acc_ready, shifted_hv,
    output pack_start, pack_idx, acc_valid, acc_last, busy, done, acc_hv
  );

  modport slave (
    output start, acc_ready, shifted_hv,
    input  pack_start, pack_idx, acc_valid, acc_last, busy, done, acc_hv
  );
endinterface

// File: rtl/enc_pack_scheduler_out_mux.sv
// enc_pack_out_mux: selects the shifted HVs of one pack for the bundler.
//   data_i : shifted HVs of all packs
//   sel_i  : pack index
//   data_o : selected pack's HVs (zero if sel_i is out of range)
module enc_pack_out_mux #(
  parameter int unsigned NUM_PACKS = 62,
  parameter int unsigned IDX_W     = 6,
  parameter int unsigned DW        = 80
) (
  input  logic [NUM_PACKS-1:0][DW-1:0] data_i,
  input  logic [IDX_W-1:0]             sel_i,
  output logic [DW-1:0]                data_o
);
  always_comb begin
    data_o = '0;
    for (int unsigned i = 0; i < NUM_PACKS; i++) begin
      if (sel_i == IDX_W'(i)) data_o = data_i[i];
    end
  end
endmodule

// File: rtl/enc_pack_scheduler.sv
// enc_pack_scheduler: issues each binder pack of one sample in turn, waits the
// binder latency, then presents the pack result to the bundler via valid/ready.
//   clk  : clock, rising edge
//   nrst : synchronous active-high reset
//   bus  : start, pack_start[], pack_idx, acc_valid/ready/last, busy, done,
//          shifted_hv[] in, acc_hv out (muxed by pack_idx)
module enc_pack_scheduler
  import enc_pack_scheduler_pkg::*;
#(
  parameter int unsigned NUM_PACKS = ENC_NUM_PACKS,
  parameter int unsigned BIND_LAT  = 1,
  parameter int unsigned IDX_W     = (NUM_PACKS > 1) ? $clog2(NUM_PACKS) : 1,
  parameter int unsigned HV_BITS   = HV_W
) (
  input logic                  clk,
  input logic                  nrst,
  enc_pack_scheduler_if.master bus
);
  localparam int unsigned    CNT_W    = (BIND_LAT > 1) ? $clog2(BIND_LAT) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PACKS - 1);

  enc_sched_state_t     state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [NUM_PACKS-1:0] pack_start_q, pack_start_d;
  logic                 acc_valid_q, acc_valid_d;
  logic                 acc_last_q, acc_last_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        idx_d = '0;
        if (bus.start) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        cnt_d   = CNT_W'(BIND_LAT - 1);
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt_q == '0) state_d = ST_PRESENT;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      ST_PRESENT: begin
        if (acc_valid_q && bus.acc_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = ST_FINISH;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = ST_ISSUE;
          end
        end
      end
      ST_FINISH: begin
        idx_d   = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered from the next state so each is valid in the
    // same cycle the FSM occupies the corresponding state.
    pack_start_d = (state_d == ST_ISSUE) ? (NUM_PACKS'(1) << idx_d) : '0;
    acc_valid_d  = (state_d == ST_PRESENT);
    acc_last_d   = (state_d == ST_PRESENT) && (idx_d == LAST_IDX);
    busy_d       = (state_d != ST_IDLE);
    done_d       = (state_d == ST_FINISH);
  end

  always_ff @(posedge clk) begin
    if (nrst) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      cnt_q        <= '0;
      pack_start_q <= '0;
      acc_valid_q  <= 1'b0;
      acc_last_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      pack_start_q <= pack_start_d;
      acc_valid_q  <= acc_valid_d;
      acc_last_q   <= acc_last_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign bus.pack_start = pack_start_q;
  assign bus.pack_idx   = idx_q;
  assign bus.acc_valid  = acc_valid_q;
  assign bus.acc_last   = acc_last_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

  enc_pack_out_mux #(
    .NUM_PACKS (NUM_PACKS),
    .IDX_W     (IDX_W),
    .DW        (PACK_W * HV_BITS)
  ) u_out_mux (
    .data_i (bus.shifted_hv),
    .sel_i  (idx_q),
    .data_o (bus.acc_hv)
  );
endmodule

// File: tb/tb_enc_pack_scheduler.sv
module tb_enc_pack_scheduler;
  import enc_pack_scheduler_pkg::*;

  logic clk = 1'b0;
  logic rst1, rst2;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  enc_pack_scheduler_if #(.NUM_PACKS(4), .IDX_W(2), .HV_BITS(8)) bif1 ();
  enc_pack_scheduler_if #(.NUM_PACKS(2), .IDX_W(1), .HV_BITS(8)) bif2 ();

  enc_pack_scheduler #(.NUM_PACKS(4), .BIND_LAT(1), .IDX_W(2), .HV_BITS(8)) dut1 (
    .clk(clk), .nrst(rst1), .bus(bif1));
  enc_pack_scheduler #(.NUM_PACKS(2), .BIND_LAT(3), .IDX_W(1), .HV_BITS(8)) dut2 (
    .clk(clk), .nrst(rst2), .bus(bif2));

  typedef struct {
    logic       start, ready, rst;
    logic [3:0] ps;
    logic [1:0] idx;
    logic       val, last, busy, done;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic s, logic r, logic rs, logic [3:0] ps, logic [1:0] idx,
                              logic val, logic last, logic busy, logic done);
    vec_t v;
    v.start = s; v.ready = r; v.rst = rs; v.ps = ps; v.idx = idx;
    v.val = val; v.last = last; v.busy = busy; v.done = done;
    return v;
  endfunction

  function automatic logic [79:0] hv_pat(int p);
    logic [7:0] b;
    b = 8'hA0 + 8'(p);
    return {10{b}};
  endfunction

  task automatic do_reset();
    rst1 = 1'b1; rst2 = 1'b1;
    bif1.start = 1'b0; bif1.acc_ready = 1'b1;
    bif2.start = 1'b0; bif2.acc_ready = 1'b1;
    @(posedge clk); #1;
    rst1 = 1'b0; rst2 = 1'b0;
  endtask

  task automatic apply(input vec_t v, input int n);
    logic [9:0] act, exp;
    bif1.start = v.start; bif1.acc_ready = v.ready; rst1 = v.rst;
    act = {bif1.pack_start, bif1.pack_idx, bif1.acc_valid, bif1.acc_last, bif1.busy, bif1.done};
    exp = {v.ps, v.idx, v.val, v.last, v.busy, v.done};
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL vec%0d outputs {ps,idx,val,last,busy,done}: got %b_%b_%b%b%b%b want %b_%b_%b%b%b%b",
               n, act[9:6], act[5:4], act[3], act[2], act[1], act[0],
               exp[9:6], exp[5:4], exp[3], exp[2], exp[1], exp[0]);
    end
    if (v.val) begin
      n_cmp++;
      if (bif1.acc_hv !== hv_pat(int'(v.idx))) begin
        n_bad++;
        $display("FAIL vec%0d acc_hv: got %h want %h", n, bif1.acc_hv, hv_pat(int'(v.idx)));
      end
    end
    @(posedge clk); #1;
  endtask

  vec_t main_run [15];

  initial begin
    for (int p = 0; p < 4; p++) bif1.shifted_hv[p] = hv_pat(p);
    bif2.shifted_hv = '0;
    do_reset();

    // NUM_PACKS=4, BIND_LAT=1, ready high, start in cycle 0
    main_run[0]  = mk(1,1,0,4'b0000,0,0,0,0,0);
    main_run[1]  = mk(0,1,0,4'b0001,0,0,0,1,0);
    main_run[2]  = mk(0,1,0,4'b0000,0,0,0,1,0);
    main_run[3]  = mk(0,1,0,4'b0000,0,1,0,1,0);
    main_run[4]  = mk(0,1,0,4'b0010,1,0,0,1,0);
    main_run[5]  = mk(0,1,0,4'b0000,1,0,0,1,0);
    main_run[6]  = mk(0,1,0,4'b0000,1,1,0,1,0);
    main_run[7]  = mk(0,1,0,4'b0100,2,0,0,1,0);
    main_run[8]  = mk(0,1,0,4'b0000,2,0,0,1,0);
    main_run[9]  = mk(0,1,0,4'b0000,2,1,0,1,0);
    main_run[10] = mk(0,1,0,4'b1000,3,0,0,1,0);
    main_run[11] = mk(0,1,0,4'b0000,3,0,0,1,0);
    main_run[12] = mk(0,1,0,4'b0000,3,1,1,1,0);
    main_run[13] = mk(0,1,0,4'b0000,3,0,0,1,1);
    main_run[14] = mk(0,1,0,4'b0000,0,0,0,0,0);

    // idle after reset
    for (int i = 0; i < 5; i++) vq.push_back(mk(0,1,0,4'b0000,0,0,0,0,0));
    // nominal sample
    for (int i = 0; i < 15; i++) vq.push_back(main_run[i]);
    // extra starts at 5 and 13 (with done) must be ignored
    for (int i = 0; i < 15; i++) begin
      vec_t v;
      v = main_run[i];
      if (i == 5 || i == 13) v.start = 1'b1;
      vq.push_back(v);
    end
    // reset during pack 2, then restart at cycle 12
    for (int i = 0; i < 8; i++) vq.push_back(main_run[i]);
    vq.push_back(mk(0,1,1,4'b0000,2,0,0,1,0));
    for (int i = 9; i < 12; i++) vq.push_back(mk(0,1,0,4'b0000,0,0,0,0,0));
    vq.push_back(mk(1,1,0,4'b0000,0,0,0,0,0));
    vq.push_back(mk(0,1,0,4'b0001,0,0,0,1,0));
    vq.push_back(mk(0,1,0,4'b0000,0,0,0,1,0));

    for (int i = 0; i < vq.size(); i++) apply(vq[i], i);

    // Backpressure: ready low for 3 cycles while pack 1 is presented
    do_reset();
    begin
      int hold1, done_cyc, done_n;
      int acc_cnt [4];
      int iss_cnt [4];
      hold1 = 0; done_cyc = -1; done_n = 0;
      for (int p = 0; p < 4; p++) begin acc_cnt[p] = 0; iss_cnt[p] = 0; end
      for (int cyc = 0; cyc < 30; cyc++) begin
        bif1.start     = (cyc == 0);
        bif1.acc_ready = !(cyc >= 6 && cyc <= 8);
        if (bif1.acc_valid && bif1.pack_idx == 2'd1) hold1++;
        if (bif1.acc_valid && bif1.acc_ready) acc_cnt[bif1.pack_idx]++;
        for (int p = 0; p < 4; p++) if (bif1.pack_start[p]) iss_cnt[p]++;
        if (bif1.done) begin done_n++; if (done_cyc < 0) done_cyc = cyc; end
        @(posedge clk); #1;
      end
      bif1.acc_ready = 1'b1;
      n_cmp++;
      if (hold1 != 4) begin n_bad++; $display("FAIL bp_hold: got %0d want 4", hold1); end
      n_cmp++;
      if (done_cyc != 16) begin n_bad++; $display("FAIL bp_done_cycle: got %0d want 16", done_cyc); end
      n_cmp++;
      if (done_n != 1) begin n_bad++; $display("FAIL bp_done_count: got %0d want 1", done_n); end
      for (int p = 0; p < 4; p++) begin
        n_cmp++;
        if (acc_cnt[p] != 1 || iss_cnt[p] != 1) begin
          n_bad++;
          $display("FAIL bp_pack%0d accepted/issued: got %0d/%0d want 1/1", p, acc_cnt[p], iss_cnt[p]);
        end
      end
    end

    // BIND_LAT=3, NUM_PACKS=2
    do_reset();
    begin
      int ps0, ps1, dn, last_seen;
      ps0 = -1; ps1 = -1; dn = -1; last_seen = -1;
      for (int cyc = 0; cyc < 20; cyc++) begin
        bif2.start = (cyc == 0);
        if (bif2.pack_start == 2'b01 && ps0 < 0) ps0 = cyc;
        if (bif2.pack_start == 2'b10 && ps1 < 0) ps1 = cyc;
        if (bif2.acc_last && last_seen < 0) last_seen = cyc;
        if (bif2.done && dn < 0) dn = cyc;
        @(posedge clk); #1;
      end
      n_cmp++;
      if (ps0 != 1) begin n_bad++; $display("FAIL bl3_pack0_start: got %0d want 1", ps0); end
      n_cmp++;
      if (ps1 != 6) begin n_bad++; $display("FAIL bl3_pack1_start: got %0d want 6", ps1); end
      n_cmp++;
      if (last_seen != 10) begin n_bad++; $display("FAIL bl3_last: got %0d want 10", last_seen); end
      n_cmp++;
      if (dn != 11) begin n_bad++; $display("FAIL bl3_done: got %0d want 11", dn); end
      n_cmp++;
      if (bif2.busy !== 1'b0) begin n_bad++; $display("FAIL bl3_idle_busy: got %b want 0", bif2.busy); end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/enc_pack_scheduler.md
Name: enc_pack_scheduler

Overview:
- Sequences a bank of encoder binder packs (10 binders per pack) for one input sample.
- Pulses each pack's start_encoding in turn and drives the pack index used to steer that pack's level HVs and shifted outputs.
- Presents each pack's result to the downstream bundler/accumulator with a valid/ready handshake.
- Sits between the sample-load logic (start) and the bundler (accumulate).

Parameters:
- NUM_PACKS, 62, number of binder packs per sample (62 x 10 = 620 feature slots).
- BIND_LAT, 1, cycles from start_encoding to valid shifted_hv in a pack (>=1).
- IDX_W, $clog2(NUM_PACKS), width of pack index.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- nrst  input  1  synchronous, active-high reset (nrst=1 resets on the clock edge).
- start  input  1  single-cycle request to encode one sample; ignored unless idle.
- pack_start  output  NUM_PACKS  one-hot start_encoding strobe, one bit per pack.
- pack_idx  output  IDX_W  index of the pack in flight; mux select for level_hv/shifted_hv.
- acc_valid  output  1  shifted HVs of pack pack_idx are valid for the bundler.
- acc_ready  input  1  bundler accepts the current pack.
- acc_last  output  1  qualifies acc_valid: the current pack is the final pack.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  single-cycle pulse when all packs have been accepted.

Behaviour:
- Reset values: pack_start=0, pack_idx=0, acc_valid=0, acc_last=0, busy=0, done=0, FSM=IDLE, wait counter=0.
- FSM states: IDLE, ISSUE, WAIT, PRESENT, FINISH.
- IDLE:
  - start=1 -> ISSUE, pack_idx=0.
  - start=0 -> stay.
- ISSUE (1 cycle):
  - pack_start[pack_idx]=1, all other bits 0.
  - Wait counter loads BIND_LAT-1, then -> WAIT.
- WAIT:
  - Counter decrements each cycle; on 0 -> PRESENT.
  - Occupies exactly BIND_LAT cycles.
- PRESENT:
  - acc_valid=1; acc_last=1 iff pack_idx==NUM_PACKS-1.
  - Holds with pack_idx stable until acc_valid&acc_ready.
  - On handshake, non-last pack: pack_idx+1 -> ISSUE.
  - On handshake, last pack: -> FINISH.
- FINISH (1 cycle): done=1, then -> IDLE. pack_idx returns to 0 on entry to IDLE.
- busy=1 in ISSUE/WAIT/PRESENT/FINISH; 0 in IDLE.
- start while busy: ignored, not queued.
- start in the same cycle done is high: ignored. The FSM is in FINISH, not IDLE.
- Timing, start sampled at edge k, acc_ready tied high:
  - Pack p is issued in cycle k+1+p*(BIND_LAT+2).
  - done is high in cycle k+NUM_PACKS*(BIND_LAT+2)+1.
- Backpressure: each cycle acc_ready=0 in PRESENT delays all later events by one cycle. No pack is skipped or reissued.
- pack_idx never exceeds NUM_PACKS-1; no wrap within a sample.
- Reset mid-operation (nrst=1 in any state): returns to reset values on that edge. No done pulse; the partial sample is abandoned.
- Registered outputs: pack_start, acc_valid, acc_last, busy, done are all registers. No combinational path from acc_ready to outputs except through state.

Decomposition:
- Shared HDC package holds:
  - the FSM state enum (enc_sched_state_t);
  - PACK_W=10;
  - the NUM_PACKS constant, derived from feature count/PACK_W with ceiling;
  - the SHIFTS table already used by binder packs.
- One natural sub-module: enc_pack_out_mux. It selects shifted_hv of pack pack_idx for the bundler, driven by this block's pack_idx.
- The FSM and counters stay in this module.

Test Plan:
- Reset, then idle 5 cycles -> all outputs 0, no pack_start.
- NUM_PACKS=4, BIND_LAT=1, acc_ready=1, start at cycle 0:
  - pack_start one-hot 0001, 0010, 0100, 1000 at cycles 1, 4, 7, 10;
  - acc_valid at cycles 3, 6, 9, 12; acc_last only at 12;
  - done at cycle 13.
- Same config, acc_ready low for 3 cycles on pack 1 -> acc_valid and pack_idx=1 held 4 cycles; done at cycle 16; each pack accepted once.
- start pulsed at cycles 0, 5 and 13 (with done) -> only one sample encoded; busy continuous 1..13; no second pack_start burst.
- nrst asserted at cycle 8 during pack 2 -> all outputs 0 at cycle 9, no done; new start at 12 restarts from pack 0.
- BIND_LAT=3, NUM_PACKS=2, ready high -> pack_start at cycles 1, 6; done at cycle 11.
